// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 16-bit-instruction fetch path.
//
// Owns the program counter and picks, each cycle, between sequential fetch
// (+PC_INC), a taken branch, a return-from-interrupt, a stall hold, or
// interrupt entry. Interrupt entry is a small FSM that saves the interrupted
// PC, then fetches the 32-bit handler address from instruction memory as two
// halfwords (low at IRQ_VEC_ADDR, high at IRQ_VEC_ADDR+2) and jumps there.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   - branch/return/handler targets with bit0=1 are loaded with
//               bit0 cleared and align_fault pulses with that pc update.
//   undefined - targets load unmodified, align_fault is constant 0.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   stall             hold PC / hold FSM state
//   branch_taken      redirect to branch_target (RUN only)
//   ret_valid         redirect to ret_addr (RUN only)
//   irq               level-sensitive interrupt request
//   mem_data          instruction memory data at address pc (same cycle)
//   pc                registered fetch address
//   flush             registered one-cycle pulse on every redirect
//   save_pc           interrupted PC, qualified by save_pc_valid pulse
//   irq_ack           one-cycle pulse when the handler address is loaded
//   in_irq_entry      high while interrupt entry is in progress
//   align_fault       one-cycle pulse on a misaligned target (option only)
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR   = 32'd30,
  parameter logic [31:0] IRQ_VEC_ADDR = 32'd0,
  parameter logic [31:0] PC_INC       = 32'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_valid,
  input  logic [31:0] ret_addr,
  input  logic        irq,
  input  logic [15:0] mem_data,
  output logic [31:0] pc,
  output logic        flush,
  output logic [31:0] save_pc,
  output logic        save_pc_valid,
  output logic        irq_ack,
  output logic        in_irq_entry,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    IRQ_SAVE   = 2'd1,
    IRQ_VEC_LO = 2'd2,
    IRQ_VEC_HI = 2'd3
  } seqState_t;

  seqState_t   stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] savePcReg, savePcNext;
  logic [15:0] vecLoReg, vecLoNext;
  logic        irqPendReg, irqPendNext;
  logic        flushReg, flushNext;
  logic        savePcValidReg, savePcValidNext;
  logic        irqAckReg, irqAckNext;
  logic        alignFaultReg, alignFaultNext;
  logic [32:0] loaded;

  // Returns {fault, address} for a target about to be loaded into pc.
  function automatic logic [32:0] alignTarget(input logic [31:0] addr);
`ifdef PC_ALIGN_CHECK_EN
    return {addr[0], addr[31:1], 1'b0};
`else
    return {1'b0, addr};
`endif
  endfunction

  // State, PC and pulse registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg       <= RUN;
      pcReg          <= RESET_ADDR;
      savePcReg      <= 32'd0;
      vecLoReg       <= 16'd0;
      irqPendReg     <= 1'b0;
      flushReg       <= 1'b0;
      savePcValidReg <= 1'b0;
      irqAckReg      <= 1'b0;
      alignFaultReg  <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      pcReg          <= pcNext;
      savePcReg      <= savePcNext;
      vecLoReg       <= vecLoNext;
      irqPendReg     <= irqPendNext;
      flushReg       <= flushNext;
      savePcValidReg <= savePcValidNext;
      irqAckReg      <= irqAckNext;
      alignFaultReg  <= alignFaultNext;
    end
  end

  // Next-state and next-PC selection; pulses default low every cycle.
  always_comb begin
    stateNext       = stateReg;
    pcNext          = pcReg;
    savePcNext      = savePcReg;
    vecLoNext       = vecLoReg;
    flushNext       = 1'b0;
    savePcValidNext = 1'b0;
    irqAckNext      = 1'b0;
    alignFaultNext  = 1'b0;
    loaded          = 33'd0;
    case (stateReg)
      RUN: begin
        // Redirects win even under stall: the stalled fetch is discarded.
        if (branch_taken) begin
          loaded         = alignTarget(branch_target);
          pcNext         = loaded[31:0];
          alignFaultNext = loaded[32];
          flushNext      = 1'b1;
        end else if (ret_valid) begin
          loaded         = alignTarget(ret_addr);
          pcNext         = loaded[31:0];
          alignFaultNext = loaded[32];
          flushNext      = 1'b1;
        end else if (irqPendReg && !stall) begin
          stateNext = IRQ_SAVE;
        end else if (stall) begin
          pcNext = pcReg;
        end else begin
          pcNext = pcReg + PC_INC;
        end
      end
      IRQ_SAVE: begin
        // Single cycle regardless of stall: the pipeline is being flushed.
        savePcNext      = pcReg;
        savePcValidNext = 1'b1;
        pcNext          = IRQ_VEC_ADDR;
        flushNext       = 1'b1;
        stateNext       = IRQ_VEC_LO;
      end
      IRQ_VEC_LO: begin
        if (stall) begin
          stateNext = IRQ_VEC_LO;
        end else begin
          vecLoNext = mem_data;
          pcNext    = IRQ_VEC_ADDR + 32'd2;
          stateNext = IRQ_VEC_HI;
        end
      end
      IRQ_VEC_HI: begin
        if (stall) begin
          stateNext = IRQ_VEC_HI;
        end else begin
          loaded         = alignTarget({mem_data, vecLoReg});
          pcNext         = loaded[31:0];
          alignFaultNext = loaded[32];
          irqAckNext     = 1'b1;
          stateNext      = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
    // Pending flag clears with the ack; a still-high irq re-arms it next cycle.
    if (irqAckNext) begin
      irqPendNext = 1'b0;
    end else if (irq) begin
      irqPendNext = 1'b1;
    end else begin
      irqPendNext = irqPendReg;
    end
  end

  assign pc            = pcReg;
  assign flush         = flushReg;
  assign save_pc       = savePcReg;
  assign save_pc_valid = savePcValidReg;
  assign irq_ack       = irqAckReg;
  assign in_irq_entry  = (stateReg != RUN);
  assign align_fault   = alignFaultReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ret_valid;
  logic [31:0] ret_addr;
  logic        irq;
  wire  [15:0] mem_data;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] save_pc;
  logic        save_pc_valid;
  logic        irq_ack;
  logic        in_irq_entry;
  logic        align_fault;

  logic [15:0] memLo;
  logic [15:0] memHi;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: entry step 0 = running, 1..3 = interrupt entry steps.
  int          mStep;
  logic [31:0] mPc;
  logic [31:0] mSavePc;
  logic [15:0] mVecLo;
  logic        mPend;
  logic        mFlush;
  logic        mSaveValid;
  logic        mAck;
  logic        mFault;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .irq(irq),
    .mem_data(mem_data), .pc(pc), .flush(flush), .save_pc(save_pc),
    .save_pc_valid(save_pc_valid), .irq_ack(irq_ack),
    .in_irq_entry(in_irq_entry), .align_fault(align_fault)
  );

  // Instruction memory: vector halfwords at 0 and 2, a pattern elsewhere.
  assign mem_data = (pc == 32'd0) ? memLo :
                    (pc == 32'd2) ? memHi : (pc[16:1] ^ 16'h5A5A);

  function automatic logic [15:0] memRead(input logic [31:0] a,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    if (a == 32'd0) return lo;
    if (a == 32'd2) return hi;
    return a[16:1] ^ 16'h5A5A;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load a redirect target into the model, applying the alignment option.
  task automatic modelLoad(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    mPc    = {t[31:1], 1'b0};
    mFault = t[0];
`else
    mPc    = t;
`endif
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic modelAdvance();
    logic [15:0] md;
    logic        acked;
    md         = memRead(mPc, memLo, memHi);
    acked      = 1'b0;
    mFlush     = 1'b0;
    mSaveValid = 1'b0;
    mAck       = 1'b0;
    mFault     = 1'b0;
    if (reset) begin
      mStep = 0; mPc = 32'd30; mPend = 1'b0; mVecLo = 16'd0; mSavePc = 32'd0;
    end else begin
      if (mStep == 0) begin
        if (branch_taken) begin
          modelLoad(branch_target); mFlush = 1'b1;
        end else if (ret_valid) begin
          modelLoad(ret_addr); mFlush = 1'b1;
        end else if (mPend && !stall) begin
          mStep = 1;
        end else if (!stall) begin
          mPc = mPc + 32'd2;
        end
      end else if (mStep == 1) begin
        mSavePc = mPc; mSaveValid = 1'b1; mPc = 32'd0; mFlush = 1'b1; mStep = 2;
      end else if (!stall) begin
        if (mStep == 2) begin
          mVecLo = md; mPc = 32'd2; mStep = 3;
        end else begin
          modelLoad({md, mVecLo}); mAck = 1'b1; acked = 1'b1; mStep = 0;
        end
      end
      if (acked) mPend = 1'b0;
      else if (irq) mPend = 1'b1;
    end
  endtask

  task automatic compareAll();
    chk("pc", pc, mPc);
    chk("flush", {31'd0, flush}, {31'd0, mFlush});
    chk("save_pc", save_pc, mSavePc);
    chk("save_pc_valid", {31'd0, save_pc_valid}, {31'd0, mSaveValid});
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, mAck});
    chk("in_irq_entry", {31'd0, in_irq_entry}, {31'd0, (mStep != 0)});
    chk("align_fault", {31'd0, align_fault}, {31'd0, mFault});
  endtask

  // One clock: model steps, DUT takes the edge, outputs compared mid-cycle.
  task automatic tick();
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleInputs();
    stall = 1'b0; branch_taken = 1'b0; ret_valid = 1'b0; irq = 1'b0;
  endtask

  task automatic branchTo(input logic [31:0] t);
    branch_taken = 1'b1; branch_target = t;
    tick();
    branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idleInputs(); branch_target = 32'd0; ret_addr = 32'd0;
    memLo = 16'h1234; memHi = 16'hABCD;
    mStep = 0; mPc = 32'd0; mSavePc = 32'd0; mVecLo = 16'd0; mPend = 1'b0;
    mFlush = 1'b0; mSaveValid = 1'b0; mAck = 1'b0; mFault = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_pc", pc, 32'd30);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    tick(); chk("idle1", pc, 32'd32);
    tick(); chk("idle2", pc, 32'd34);
    tick(); chk("idle3", pc, 32'd36);
    tick(); tick(); chk("at40", pc, 32'd40);

    // Branch under stall still redirects.
    stall = 1'b1;
    branchTo(32'h100);
    stall = 1'b0;
    chk("br_pc", pc, 32'h100);
    chk("br_flush", {31'd0, flush}, 32'd1);
    tick(); chk("br_flush_off", {31'd0, flush}, 32'd0);
    chk("br_seq", pc, 32'h102);

    // Interrupt entry with pc=0x50 at the decision point.
    branchTo(32'h4E);
    irq = 1'b1; tick(); irq = 1'b0;
    chk("irq_dec_pc", pc, 32'h50);
    tick(); chk("irq_entry", {31'd0, in_irq_entry}, 32'd1);
    tick(); chk("irq_save", save_pc, 32'h50);
    chk("irq_save_v", {31'd0, save_pc_valid}, 32'd1);
    chk("irq_vec0", pc, 32'd0);
    tick(); chk("irq_vec2", pc, 32'd2);
    tick(); chk("irq_handler", pc, 32'hABCD1234);
    chk("irq_ack", {31'd0, irq_ack}, 32'd1);
    chk("irq_run", {31'd0, in_irq_entry}, 32'd0);

    // Same entry with two stall cycles in the low-halfword fetch.
    branchTo(32'h4E);
    irq = 1'b1; tick(); irq = 1'b0;
    tick(); tick();
    stall = 1'b1;
    tick(); chk("stall_vec0a", pc, 32'd0);
    tick(); chk("stall_vec0b", pc, 32'd0);
    stall = 1'b0;
    tick(); chk("stall_vec2", pc, 32'd2);
    tick(); chk("stall_handler", pc, 32'hABCD1234);

    // 32-bit wrap, then return-from-interrupt.
    branchTo(32'hFFFFFFFC);
    tick(); chk("wrap_fe", pc, 32'hFFFFFFFE);
    tick(); chk("wrap_0", pc, 32'd0);
    ret_valid = 1'b1; ret_addr = 32'h52; tick(); ret_valid = 1'b0;
    chk("ret_pc", pc, 32'h52);
    chk("ret_flush", {31'd0, flush}, 32'd1);

    // Odd branch target.
    branchTo(32'h101);
`ifdef PC_ALIGN_CHECK_EN
    chk("odd_pc", pc, 32'h100);
    chk("odd_fault", {31'd0, align_fault}, 32'd1);
`else
    chk("odd_pc", pc, 32'h101);
    chk("odd_fault", {31'd0, align_fault}, 32'd0);
`endif
    tick(); chk("odd_fault_off", {31'd0, align_fault}, 32'd0);

    // Randomized traffic, including resets during interrupt entry.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(99) == 0);
      stall         = ($urandom_range(9) < 3);
      branch_taken  = ($urandom_range(9) == 0);
      ret_valid     = ($urandom_range(19) == 0);
      irq           = ($urandom_range(11) == 0);
      branch_target = $urandom;
      ret_addr      = $urandom;
      if ($urandom_range(3) != 0) branch_target[0] = 1'b0;
      if ($urandom_range(3) != 0) ret_addr[0] = 1'b0;
      if ($urandom_range(15) == 0) memLo = 16'($urandom);
      if ($urandom_range(15) == 0) memHi = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
